// File: rtl/mmc_rsp_rx.sv
// mmc_rsp_rx: bit-serial receiver for MMC command-line responses.
// Armed after a command's end bit, waits for the card's start bit, shifts in a
// 48-bit (R1/R1b/R3/R6) or 136-bit (R2) response, checks framing and CRC7
// (x^7+x^3+1), and returns the response fields plus error status.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bit_en_i        one-clk strobe per MMC bit period; cmd_in_i sampled only then
//   cmd_in_i        synchronised CMD line level
//   arm_i           start a reception (ignored while busy)
//   long_rsp_i      sampled on arm: 1 = 136-bit R2, 0 = 48-bit
//   chk_crc_i       sampled on arm: 0 disables the CRC compare
//   busy_o          reception in progress
//   done_o          one-clk pulse at the end of a reception
//   rsp_index_o     short: bits[45:40]; long: 6'h3F
//   rsp_data_o      short: {88'b0, bits[39:8]}; long: bits[127:8]
//   err_to_o/err_tx_o/err_crc_o/err_end_o  timeout / tx bit / CRC / end bit errors
module mmc_rsp_rx #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned TW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en_i,
  input  logic         cmd_in_i,
  input  logic         arm_i,
  input  logic         long_rsp_i,
  input  logic         chk_crc_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [5:0]   rsp_index_o,
  output logic [119:0] rsp_data_o,
  output logic         err_to_o,
  output logic         err_tx_o,
  output logic         err_crc_o,
  output logic         err_end_o
);

  localparam int unsigned BW       = 7;
  localparam int unsigned DW       = 120;
  localparam int unsigned SHORT_PL = 38;
  localparam int unsigned LONG_PL  = 126;

  typedef enum logic [2:0] {IDLE, WAIT, TXB, PAY, CRC, ENDB, FIN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      ccnt_q, ccnt_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [6:0]      crc_q, crc_d;
  logic [6:0]      rcrc_q, rcrc_d;
  logic            long_q, long_d;
  logic            chk_q, chk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [5:0]      index_q, index_d;
  logic [DW-1:0]   data_q, data_d;
  logic            to_q, to_d, tx_q, tx_d, ecrc_q, ecrc_d, end_q, end_d;
  logic [6:0]      crc_upd;

  // One CRC7 step with the current line bit.
  function automatic logic [6:0] crc_next(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:4], c[3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign crc_upd = crc_next(crc_q, cmd_in_i);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      ccnt_q  <= '0;
      sh_q    <= '0;
      crc_q   <= '0;
      rcrc_q  <= '0;
      long_q  <= 1'b0;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      to_q    <= 1'b0;
      tx_q    <= 1'b0;
      ecrc_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      rcrc_q  <= rcrc_d;
      long_q  <= long_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      index_q <= index_d;
      data_q  <= data_d;
      to_q    <= to_d;
      tx_q    <= tx_d;
      ecrc_q  <= ecrc_d;
      end_q   <= end_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    ccnt_d  = ccnt_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    rcrc_d  = rcrc_q;
    long_d  = long_q;
    chk_d   = chk_q;
    index_d = index_q;
    data_d  = data_q;
    to_d    = to_q;
    tx_d    = tx_q;
    ecrc_d  = ecrc_q;
    end_d   = end_q;

    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          long_d  = long_rsp_i;
          chk_d   = chk_crc_i;
          to_d    = 1'b0;
          tx_d    = 1'b0;
          ecrc_d  = 1'b0;
          end_d   = 1'b0;
          tcnt_d  = '0;
          crc_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bit_en_i) begin
          if (!cmd_in_i) begin
            if (!long_q) crc_d = crc_upd;
            state_d = TXB;
          end else if (tcnt_q == TW'(NCR_MAX - 1)) begin
            to_d    = 1'b1;
            state_d = FIN;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      TXB: begin
        if (bit_en_i) begin
          tx_d    = cmd_in_i;
          // R2 CRC covers only the payload, so the register restarts here.
          crc_d   = long_q ? 7'd0 : crc_upd;
          bcnt_d  = long_q ? BW'(LONG_PL) : BW'(SHORT_PL);
          state_d = PAY;
        end
      end
      PAY: begin
        if (bit_en_i) begin
          // R2 reserved bits fall off the top of the 120-bit register.
          sh_d = {sh_q[DW-2:0], cmd_in_i};
          if (!long_q || bcnt_q <= BW'(DW)) crc_d = crc_upd;
          bcnt_d = bcnt_q - 1'b1;
          if (bcnt_q == BW'(1)) begin
            ccnt_d  = 3'd7;
            state_d = CRC;
          end
        end
      end
      CRC: begin
        if (bit_en_i) begin
          rcrc_d = {rcrc_q[5:0], cmd_in_i};
          ccnt_d = ccnt_q - 1'b1;
          if (ccnt_q == 3'd1) state_d = ENDB;
        end
      end
      ENDB: begin
        if (bit_en_i) begin
          end_d  = ~cmd_in_i;
          ecrc_d = chk_q & (rcrc_q != crc_q);
          if (long_q) begin
            index_d = 6'h3F;
            data_d  = sh_q;
          end else begin
            index_d = sh_q[37:32];
            data_d  = {88'd0, sh_q[31:0]};
          end
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // done is high exactly while in FIN; busy drops on that same clk.
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rsp_index_o = index_q;
  assign rsp_data_o  = data_q;
  assign err_to_o    = to_q;
  assign err_tx_o    = tx_q;
  assign err_crc_o   = ecrc_q;
  assign err_end_o   = end_q;

endmodule

// File: tb/tb_mmc_rsp_rx.sv
// tb_mmc_rsp_rx: directed bench for mmc_rsp_rx with hand-computed short frames
// and a reference CRC7 (polynomial long division) for the R2 frame.
module tb_mmc_rsp_rx;

  localparam int unsigned NCR_MAX = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_en_i, cmd_in_i, arm_i, long_rsp_i, chk_crc_i;
  logic         busy_o, done_o;
  logic [5:0]   rsp_index_o;
  logic [119:0] rsp_data_o;
  logic         err_to_o, err_tx_o, err_crc_o, err_end_o;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  mmc_rsp_rx #(.NCR_MAX(NCR_MAX), .TW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en_i   (bit_en_i),
    .cmd_in_i   (cmd_in_i),
    .arm_i      (arm_i),
    .long_rsp_i (long_rsp_i),
    .chk_crc_i  (chk_crc_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rsp_index_o(rsp_index_o),
    .rsp_data_o (rsp_data_o),
    .err_to_o   (err_to_o),
    .err_tx_o   (err_tx_o),
    .err_crc_o  (err_crc_o),
    .err_end_o  (err_end_o)
  );

  always #5 clk = ~clk;

  // Count done pulses (one count per clk that done is high).
  always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [119:0] act, input logic [119:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // CRC7 as remainder of M(x)*x^7 / (x^7+x^3+1).
  function automatic logic [6:0] crc7_ref(input logic [119:0] d, input int n);
    logic [7:0] r;
    logic       b;
    r = '0;
    for (int i = 0; i < n + 7; i++) begin
      b = 1'b0;
      if (i < n) b = d[n-1-i];
      r = {r[6:0], b};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  task automatic bit_period(input logic v, input int div);
    for (int k = 0; k < div; k++) begin
      @(negedge clk);
      cmd_in_i = v;
      bit_en_i = (k == div - 1);
    end
  endtask

  task automatic send_bits(input logic [135:0] f, input int hi, input int lo, input int div);
    for (int i = hi; i >= lo; i--) bit_period(f[i], div);
  endtask

  task automatic arm(input logic lng, input logic chk);
    @(negedge clk);
    bit_en_i   = 1'b0;
    arm_i      = 1'b1;
    long_rsp_i = lng;
    chk_crc_i  = chk;
    @(negedge clk);
    arm_i = 1'b0;
  endtask

  // Return the line to idle, wait (bounded) for done, expect exactly one pulse.
  task automatic finish_frame(input int snap, input string tag);
    @(negedge clk);
    bit_en_i = 1'b0;
    cmd_in_i = 1'b1;
    for (int k = 0; k < 16 && done_cnt == snap; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 120'(done_cnt - snap), 120'd1);
    check({tag, "_busy"}, 120'(busy_o), 120'd0);
  endtask

  task automatic run_short(input logic [47:0] fr, input logic chk, input int div, input string tag);
    logic [135:0] f;
    int snap;
    f = 136'(fr);
    snap = done_cnt;
    arm(1'b0, chk);
    send_bits(136'h7, 2, 0, div);
    send_bits(f, 47, 0, div);
    finish_frame(snap, tag);
  endtask

  initial begin
    logic [119:0] pay;
    logic [135:0] lf;
    logic [47:0]  f5;
    int           n, snap;
    logic         seen, busy_ok;

    rst = 1'b1; bit_en_i = 1'b0; cmd_in_i = 1'b1; arm_i = 1'b0;
    long_rsp_i = 1'b0; chk_crc_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 120'(busy_o), 120'd0);
    check("rst_done", 120'(done_o), 120'd0);
    check("rst_index", 120'(rsp_index_o), 120'd0);
    check("rst_data", rsp_data_o, 120'd0);
    check("rst_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'd0);

    // 1: good R1, CRC7(11_00000000)=0x60 -> byte C1
    run_short(48'h11_0000_0000_C1, 1'b1, 1, "t1");
    check("t1_index", 120'(rsp_index_o), 120'h11);
    check("t1_data", rsp_data_o, 120'd0);
    check("t1_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0000);

    // 2: bad CRC, then the same with the compare disabled
    run_short(48'h11_0000_0000_C3, 1'b1, 1, "t2a");
    check("t2a_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0010);
    run_short(48'h11_0000_0000_C3, 1'b0, 1, "t2b");
    check("t2b_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0000);

    // 3: timeout, line idle after arm
    snap = done_cnt;
    arm(1'b0, 1'b1);
    check("t3_busy_arm", 120'(busy_o), 120'd1);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    cmd_in_i = 1'b1;
    while (!seen && n < 100) begin
      bit_en_i = 1'b1;
      n++;
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else if (!busy_o) busy_ok = 1'b0;
    end
    bit_en_i = 1'b0;
    check("t3_periods", 120'(n), 120'(NCR_MAX));
    check("t3_busy_held", 120'(busy_ok), 120'd1);
    check("t3_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b1000);
    repeat (3) @(negedge clk);
    check("t3_done", 120'(done_cnt - snap), 120'd1);

    // 4: R2 with correct CRC and end bit 0
    pay = 120'h0123456789ABCDEF0123456789CDEF;
    lf  = {2'b00, 6'h3F, pay, crc7_ref(pay, 120), 1'b0};
    snap = done_cnt;
    arm(1'b1, 1'b1);
    send_bits(136'h3, 1, 0, 1);
    send_bits(lf, 135, 0, 1);
    finish_frame(snap, "t4");
    check("t4_data", rsp_data_o, pay);
    check("t4_index", 120'(rsp_index_o), 120'h3F);
    check("t4_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0001);

    // 5: tx bit = 1 (0x51 adds x^45 term: CRC 0x60^0x4A=0x2A -> byte 55),
    //    bit_en every 4th clk, stray arm mid-payload
    f5 = 48'h51_0000_0000_55;
    snap = done_cnt;
    arm(1'b0, 1'b1);
    send_bits(136'h3, 1, 0, 4);
    send_bits(136'(f5), 47, 28, 4);
    arm(1'b1, 1'b0);
    check("t5_busy_mid", 120'(busy_o), 120'd1);
    send_bits(136'(f5), 27, 0, 4);
    finish_frame(snap, "t5");
    check("t5_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0100);
    check("t5_index", 120'(rsp_index_o), 120'h11);
    check("t5_data", rsp_data_o, 120'd0);

    // 6: reset mid-payload, then a clean reception
    snap = done_cnt;
    arm(1'b0, 1'b1);
    send_bits(136'(48'h11_0000_0000_C1), 47, 30, 1);
    @(negedge clk);
    bit_en_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 120'(busy_o), 120'd0);
    check("t6_done", 120'(done_o), 120'd0);
    check("t6_index", 120'(rsp_index_o), 120'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_nodone", 120'(done_cnt - snap), 120'd0);
    run_short(48'h11_0000_0000_C1, 1'b1, 1, "t6b");
    check("t6b_index", 120'(rsp_index_o), 120'h11);
    check("t6b_err", 120'({err_to_o, err_tx_o, err_crc_o, err_end_o}), 120'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
